// File: rtl/math_game_pkg.sv
// Shared types, constants and mod-100 arithmetic for the mental-arithmetic game engine.
package math_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_ANSWER,
        ST_RESULT
    } state_t;

    localparam logic [6:0] LED_WIN   = 7'h7F;
    localparam logic [6:0] LED_LOSE  = 7'h55;

    // x^8+x^6+x^5+x^4+1 on a left-shifting register: feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [6:0] add_mod100(input logic [6:0] t, input logic [5:0] n);
        logic [7:0] sum;
        sum = {1'b0, t} + {2'b00, n};
        if (sum >= 8'd100) begin
            sum = sum - 8'd100;
        end
        return sum[6:0];
    endfunction

    // The wrapped result is always below 100, so 7-bit modular arithmetic is exact here
    function automatic logic [6:0] sub_mod100(input logic [6:0] t, input logic [5:0] n);
        logic [6:0] nn;
        nn = {1'b0, n};
        if (t >= nn) begin
            return t - nn;
        end
        return t + 7'd100 - nn;
    endfunction

endpackage

// File: rtl/bin2bcd99.sv
// Combinational 7-bit binary to two BCD digits, saturating the input at 99.
module bin2bcd99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units
);

    logic [6:0] rem;

    always_comb begin
        rem  = (bin > 7'd99) ? 7'd99 : bin;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        units = rem[3:0];
    end

endmodule

// File: rtl/math_game_core.sv
// Game engine: shows LFSR operands for R rounds, collects an answer and scores it
// against the running total modulo 100.
module math_game_core
    import math_game_pkg::*;
#(
    parameter int         NUM_W         = 5,
    parameter int         MAX_ROUNDS    = 8,
    parameter int         SHOW_CYCLES   = 5,
    parameter int         ANSWER_CYCLES = 15,
    parameter int         RESULT_CYCLES = 4,
    parameter logic [7:0] SEED          = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] rounds_in,
    input  logic       mode,
    input  logic [6:0] answer,
    input  logic       submit,
    output logic [3:0] disp_tens,
    output logic [3:0] disp_units,
    output logic [6:0] disp_value,
    output logic [6:0] led,
    output logic       busy,
    output logic       correct,
    output logic [3:0] score
);

    localparam int MAX_SA  = (SHOW_CYCLES > ANSWER_CYCLES) ? SHOW_CYCLES : ANSWER_CYCLES;
    localparam int MAX_CYC = (MAX_SA > RESULT_CYCLES) ? MAX_SA : RESULT_CYCLES;
    localparam int PHASE_W = $clog2(MAX_CYC + 1);

    localparam logic [PHASE_W-1:0] SHOW_LAST   = PHASE_W'(SHOW_CYCLES - 1);
    localparam logic [PHASE_W-1:0] ANSWER_LAST = PHASE_W'(ANSWER_CYCLES - 1);
    localparam logic [PHASE_W-1:0] RESULT_LAST = PHASE_W'(RESULT_CYCLES - 1);

    state_t             state;
    logic [7:0]         lfsr;
    logic [6:0]         total;
    logic [3:0]         rounds_q;
    logic [3:0]         round_idx;
    logic               mode_q;
    logic [PHASE_W-1:0] phase;

    logic [5:0] operand;
    logic [3:0] rounds_clamped;
    logic [6:0] answer_sat;
    logic       answer_match;
    logic       sub_next;

    always_comb begin
        operand = 6'(lfsr[NUM_W-1:0]);
        if (operand == 6'd0) begin
            operand = 6'd1;
        end
        if (rounds_in == 4'd0) begin
            rounds_clamped = 4'd1;
        end else if (rounds_in > 4'(MAX_ROUNDS)) begin
            rounds_clamped = 4'(MAX_ROUNDS);
        end else begin
            rounds_clamped = rounds_in;
        end
        answer_sat   = (answer > 7'd99) ? 7'd99 : answer;
        answer_match = (answer == total);
        // round_idx is the 0-based current round; the next round is even when it is even
        sub_next     = mode_q & ~round_idx[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            lfsr       <= SEED;
            total      <= 7'd0;
            rounds_q   <= 4'd0;
            round_idx  <= 4'd0;
            mode_q     <= 1'b0;
            phase      <= '0;
            disp_value <= 7'd0;
            led        <= 7'd0;
            busy       <= 1'b0;
            correct    <= 1'b0;
            score      <= 4'd0;
        end else begin
            lfsr    <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
            correct <= 1'b0;
            case (state)
                ST_IDLE: begin
                    disp_value <= {3'b000, rounds_clamped};
                    led        <= 7'd0;
                    if (start) begin
                        state      <= ST_SHOW;
                        busy       <= 1'b1;
                        rounds_q   <= rounds_clamped;
                        mode_q     <= mode;
                        round_idx  <= 4'd0;
                        phase      <= '0;
                        total      <= add_mod100(7'd0, operand);
                        disp_value <= {1'b0, operand};
                        led        <= {1'b0, operand};
                    end
                end
                ST_SHOW: begin
                    if (phase == SHOW_LAST) begin
                        phase <= '0;
                        if (round_idx == rounds_q - 4'd1) begin
                            state      <= ST_ANSWER;
                            disp_value <= answer_sat;
                            led        <= 7'd0;
                        end else begin
                            round_idx  <= round_idx + 4'd1;
                            total      <= sub_next ? sub_mod100(total, operand)
                                                   : add_mod100(total, operand);
                            disp_value <= {1'b0, operand};
                            led        <= {sub_next, operand};
                        end
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                ST_ANSWER: begin
                    disp_value <= answer_sat;
                    if (submit || phase == ANSWER_LAST) begin
                        state      <= ST_RESULT;
                        phase      <= '0;
                        disp_value <= total;
                        led        <= answer_match ? LED_WIN : LED_LOSE;
                        correct    <= answer_match;
                        if (answer_match && score != 4'd15) begin
                            score <= score + 4'd1;
                        end
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                ST_RESULT: begin
                    if (phase == RESULT_LAST) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        phase      <= '0;
                        disp_value <= {3'b000, rounds_clamped};
                        led        <= 7'd0;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    bin2bcd99 u_bcd (
        .bin   (disp_value),
        .tens  (disp_tens),
        .units (disp_units)
    );

endmodule

// File: doc/math_game_core.md
# math_game_core

Parametrised game engine for the CPLD mental-arithmetic game. It draws pseudo-random operands from a free-running LFSR and shows them for a user-selected number of rounds. It then collects the player's answer, compares it with the running total modulo 100, and reports the result. It replaces the fixed add-only game loop. It sits between the board switches/buttons and the two-digit BCD display and LED bank, and adds selectable add/alternating-subtract mode, early submit, a start handshake and a score counter.

## Interface
- NUM_W, 5: operand width in bits; legal range 2..6, so every operand is below 100.
- MAX_ROUNDS, 8: upper clamp for the requested round count; legal range 1..15.
- SHOW_CYCLES, 5: cycles each operand is displayed; minimum 1.
- ANSWER_CYCLES, 15: maximum answer window in cycles; minimum 1.
- RESULT_CYCLES, 4: cycles the verdict is shown; minimum 1.
- SEED, 8'hA5: LFSR reset value; must be non-zero.
- clk, in, 1: single system clock; all state is updated on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: level input; sampled only in IDLE; high launches a game.
- rounds_in, in, 4: requested round count.
- mode, in, 1: 0 = all operands added; 1 = odd rounds add, even rounds subtract. Latched at start.
- answer, in, 7: player's answer in binary.
- submit, in, 1: ends the answer window early.
- disp_tens / disp_units, out, 4 each: BCD digits of disp_value.
- disp_value, out, 7: registered binary display value, 0..99.
- led, out, 7: LED bank.
- busy, out, 1: high in every state except IDLE.
- correct, out, 1: one-cycle pulse on entry to RESULT when the answer matched.
- score, out, 4: count of correct games, saturating at 15.

## Operation
- States: IDLE → SHOW → ANSWER → RESULT → IDLE.
- IDLE:
  - disp_value = R, where R = clamp(rounds_in, 1, MAX_ROUNDS).
  - led = 0.
  - On start = 1: latch R and mode, clear total and round index, draw operand 1, enter SHOW.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts every cycle in every state, so operands depend on when start is pressed.
- Operand:
  - n = lfsr[NUM_W-1:0]; if n = 0, substitute n = 1.
  - A new operand is drawn on the edge that begins each round.
- Total update, applied when the operand is drawn; total is kept 0..99 (7 bits):
  - Add: t = t + n; if t ≥ 100, subtract 100.
  - Subtract: t = t − n; if t < 0, add 100.
  - Round 1 always adds.
- SHOW:
  - disp_value = n.
  - led[6] = 1 for a subtract round; led[5:0] = n, zero-extended.
  - After SHOW_CYCLES cycles, either draw the next operand or, if that was round R, enter ANSWER.
- ANSWER:
  - disp_value = min(answer, 99).
  - led = 0.
  - The window ends on submit = 1 or after ANSWER_CYCLES cycles, whichever comes first.
  - The answer value on the ending edge is compared with t; match means answer == t exactly, so values ≥ 100 never match.
- RESULT:
  - disp_value = t.
  - led = 7'h7F if correct, 7'h55 if not.
  - correct pulses in the first cycle only; score increments (saturating) in the same cycle.
  - After RESULT_CYCLES cycles, return to IDLE.
- start is ignored outside IDLE.
- submit is ignored outside ANSWER, including while in SHOW.

## Timing
- All outputs are registered.
- disp_tens and disp_units are combinational from disp_value, with no added latency.
- Start edge k: operand 1 is visible from cycle k+1 to k+SHOW_CYCLES.
- SHOW occupies exactly R·SHOW_CYCLES cycles, with no gap between rounds.
- ANSWER follows immediately; disp_value tracks answer with one cycle of lag.
- Submit sampled at edge m: RESULT is visible from m+1.
- A timeout ends the window after exactly ANSWER_CYCLES cycles.
- RESULT lasts RESULT_CYCLES cycles; IDLE is re-entered with busy = 0 on the following cycle.
- Reset values:
  - state IDLE, lfsr = SEED, t = 0, score = 0.
  - led = 0, correct = 0, busy = 0, disp_value = 0.
- Reset mid-game: the game is aborted immediately and nothing is carried over, including the score.
- Holding start high through a whole game starts a new game on the first IDLE cycle.

## Structure
- Package math_game_pkg holds:
  - the state enum;
  - LED_WIN = 7'h7F and LED_LOSE = 7'h55;
  - the LFSR tap constant;
  - the mod-100 add/subtract helper functions.
- Sub-module bin2bcd99: combinational 7-bit binary to two BCD digits; input saturates at 99.
- The LFSR, phase counter and round counter stay inline.

## Test plan
- Clamp: rounds_in = 0 → disp_value = 1 in IDLE; rounds_in = 12 → 8 shown, and exactly 8 operands are displayed (40 SHOW cycles) before ANSWER.
- Add game: mode = 0, R = 3, answer = model total, no submit → ANSWER lasts 15 cycles, led = 7'h7F, correct pulses once, score = 1.
- Subtract wrap: mode = 1, preload chosen by picking a start cycle so the model yields t = 3 then n = 10 → t = 93; answer 93 → win.
- Early submit: submit in the 2nd ANSWER cycle with a wrong answer → RESULT on the next cycle, led = 7'h55, score unchanged.
- Reset: assert rst in the 4th SHOW cycle of round 2 → next cycle all outputs are at reset values, and the LFSR equals SEED.
- Saturation and boundaries: 16 winning games → score stays at 15; answer = 100 never matches; start and submit pulses outside their states are ignored.
